bu_req_arb: RTL and testbench

BU_REQ_ARB -- requirements
Module: bu_req_arb

---
 rtl/bu_req_arb_if.sv | 59 +++++
 rtl/bu_req_arb.sv | 126 ++++++++++++
 tb/tb_bu_req_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bu_req_arb_if.sv
// Channel-side and bus-unit-side signal bundle for the bus-unit request arbiter.
interface bu_req_arb_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 64,
  parameter int unsigned DW  = 64
);
  localparam int unsigned GW = $clog2(NCH);

  // Channel side
  logic [NCH-1:0]    ch_wt_req;
  logic [NCH-1:0]    ch_rd_req;
  logic [NCH-1:0]    ch_rdl_req;
  logic [NCH*4-1:0]  ch_size;
  logic [NCH*AW-1:0] ch_pa;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     ch_rdata;
  logic [10:0]       ch_addr_count;
  logic [NCH-1:0]    ch_line_write;
  logic [NCH-1:0]    ch_entry_write;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH-1:0]    ch_err;

  // Bus-unit side
  logic              bu_wt_req;
  logic              bu_rd_req;
  logic              bu_rdl_req;
  logic [3:0]        bu_size;
  logic [AW-1:0]     bu_pa;
  logic [DW-1:0]     bu_wdata;
  logic [DW-1:0]     bu_rdata;
  logic [10:0]       bu_addr_count;
  logic              bu_line_write;
  logic              bu_entry_write;
  logic              bu_rdy;
  logic              bu_err;

  // Status
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              tmo_pulse;

  // Arbiter view
  modport slave (
    input  ch_wt_req, ch_rd_req, ch_rdl_req, ch_size, ch_pa, ch_wdata,
    input  bu_rdata, bu_addr_count, bu_line_write, bu_entry_write, bu_rdy, bu_err,
    output ch_rdata, ch_addr_count, ch_line_write, ch_entry_write, ch_rdy, ch_err,
    output bu_wt_req, bu_rd_req, bu_rdl_req, bu_size, bu_pa, bu_wdata,
    output grant_id, busy, tmo_pulse
  );

  // Environment view (channels plus bus unit)
  modport master (
    output ch_wt_req, ch_rd_req, ch_rdl_req, ch_size, ch_pa, ch_wdata,
    output bu_rdata, bu_addr_count, bu_line_write, bu_entry_write, bu_rdy, bu_err,
    input  ch_rdata, ch_addr_count, ch_line_write, ch_entry_write, ch_rdy, ch_err,
    input  bu_wt_req, bu_rd_req, bu_rdl_req, bu_size, bu_pa, bu_wdata,
    input  grant_id, busy, tmo_pulse
  );
endinterface

// File: rtl/bu_req_arb.sv
// Bus-unit request arbiter: picks one of NCH channels (fixed or round-robin), holds the
// grant until the bus unit reports rdy/err or the timeout fires, and routes feedback.
module bu_req_arb #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 64,
  parameter int unsigned DW  = 64,
  parameter int unsigned RR  = 0,
  parameter int unsigned TMO = 1023
) (
  input  logic         clk,
  input  logic         rst,
  bu_req_arb_if.slave  io_bus
);
  localparam int unsigned GW = $clog2(NCH);
  localparam int unsigned CW = $clog2(TMO + 2);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         r_state, w_state_d;
  logic [GW-1:0]  r_grant_id, w_grant_id_d;
  logic [GW-1:0]  r_last_grant, w_last_grant_d;
  logic [CW-1:0]  r_cnt, w_cnt_d;

  logic [NCH-1:0] w_req;
  logic           w_any_req;
  logic [GW-1:0]  w_pick;
  logic [GW-1:0]  w_idx;
  logic           w_found;
  logic           w_busy;
  logic [GW-1:0]  w_gid;
  logic           w_tmo;
  logic           w_done;
  logic [NCH-1:0] w_onehot;

  assign w_req     = io_bus.ch_wt_req | io_bus.ch_rd_req | io_bus.ch_rdl_req;
  assign w_any_req = |w_req;

  // Outputs read as reset values while rst is held, even mid-grant.
  assign w_busy = (r_state == StGrant) && !rst;
  assign w_gid  = rst ? '0 : r_grant_id;

  // Timeout fires in the TMO-th grant cycle; rdy/err in that cycle take precedence.
  assign w_tmo  = (TMO != 0) && w_busy && (r_cnt == CW'(TMO - 1)) &&
                  !io_bus.bu_rdy && !io_bus.bu_err;
  assign w_done = w_busy && (io_bus.bu_rdy || io_bus.bu_err || w_tmo);

  // Arbitration: highest index (fixed) or first requester after last_grant (round-robin).
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (RR == 0) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_req[GW'(i)]) w_pick = GW'(i);
      end
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        w_idx = GW'((32'(r_last_grant) + k) % NCH);
        if (!w_found && w_req[w_idx]) begin
          w_found = 1'b1;
          w_pick  = w_idx;
        end
      end
    end
  end

  // Next-state: IDLE -> GRANT on any request, GRANT -> IDLE on completion or timeout.
  always_comb begin
    w_state_d      = r_state;
    w_grant_id_d   = r_grant_id;
    w_last_grant_d = r_last_grant;
    w_cnt_d        = '0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d      = StGrant;
          w_grant_id_d   = w_pick;
          w_last_grant_d = w_pick;
        end
      end
      StGrant: begin
        w_cnt_d = r_cnt + CW'(1);
        if (w_done) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NCH - 1);
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_grant_id   <= w_grant_id_d;
      r_last_grant <= w_last_grant_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign w_onehot = w_busy ? (NCH'(1) << w_gid) : '0;

  assign io_bus.bu_wt_req      = io_bus.ch_wt_req[w_gid] & w_busy;
  assign io_bus.bu_rd_req      = io_bus.ch_rd_req[w_gid] & w_busy;
  assign io_bus.bu_rdl_req     = io_bus.ch_rdl_req[w_gid] & w_busy;
  assign io_bus.bu_size        = io_bus.ch_size[w_gid*4 +: 4];
  assign io_bus.bu_pa          = io_bus.ch_pa[w_gid*AW +: AW];
  assign io_bus.bu_wdata       = io_bus.ch_wdata[w_gid*DW +: DW];

  assign io_bus.ch_rdata       = io_bus.bu_rdata;
  assign io_bus.ch_addr_count  = io_bus.bu_addr_count;
  assign io_bus.ch_line_write  = w_onehot & {NCH{io_bus.bu_line_write}};
  assign io_bus.ch_entry_write = w_onehot & {NCH{io_bus.bu_entry_write}};
  assign io_bus.ch_rdy         = w_onehot & {NCH{io_bus.bu_rdy}};
  assign io_bus.ch_err         = w_onehot & {NCH{io_bus.bu_err | w_tmo}};

  assign io_bus.grant_id       = w_gid;
  assign io_bus.busy           = w_busy;
  assign io_bus.tmo_pulse      = w_tmo;
endmodule

// File: tb/tb_bu_req_arb.sv
// Randomized scoreboard bench: a fixed-priority and a round-robin arbiter share one
// stimulus stream; a transaction-level model predicts each cycle and each completion.
module tb_bu_req_arb;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;
  localparam int          NCYC = 1500;

  logic         clk;
  logic         rst;
  logic [3:0]   t_wt, t_rd, t_rdl;
  logic [15:0]  t_size;
  logic [127:0] t_pa, t_wd;
  logic [31:0]  t_rdata;
  logic [10:0]  t_ac;
  logic         t_lw, t_ew, t_rdy, t_err;

  // Observed outputs per DUT, packed:
  // busy gid rq[3] rdy[4] err[4] lw[4] ew[4] tmo pa[32] size[4] wdata[32] rdata[32] ac[11]
  logic [133:0] act [2];

  logic [133:0] eq0 [$];
  logic [133:0] eq1 [$];
  logic [10:0]  cq0 [$];
  logic [10:0]  cq1 [$];

  int n_total = 0;
  int n_bad   = 0;

  // Model state per DUT: busy, owner, cycles spent in grant, last granted channel.
  bit mb [2];
  int mo [2];
  int mc [2];
  int ml [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bu_req_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) u_if ();
    assign u_if.ch_wt_req      = t_wt;
    assign u_if.ch_rd_req      = t_rd;
    assign u_if.ch_rdl_req     = t_rdl;
    assign u_if.ch_size        = t_size;
    assign u_if.ch_pa          = t_pa;
    assign u_if.ch_wdata       = t_wd;
    assign u_if.bu_rdata       = t_rdata;
    assign u_if.bu_addr_count  = t_ac;
    assign u_if.bu_line_write  = t_lw;
    assign u_if.bu_entry_write = t_ew;
    assign u_if.bu_rdy         = t_rdy;
    assign u_if.bu_err         = t_err;

    bu_req_arb #(.NCH(NCH), .AW(AW), .DW(DW), .RR(g), .TMO(TMO)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (u_if)
    );

    assign act[g] = {u_if.busy, u_if.grant_id, u_if.bu_wt_req, u_if.bu_rd_req,
                     u_if.bu_rdl_req, u_if.ch_rdy, u_if.ch_err, u_if.ch_line_write,
                     u_if.ch_entry_write, u_if.tmo_pulse, u_if.bu_pa, u_if.bu_size,
                     u_if.bu_wdata, u_if.ch_rdata, u_if.ch_addr_count};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Predict this cycle's outputs from the current inputs, then advance the model.
  task automatic model_step(input int m);
    logic [133:0] e;
    logic [3:0]   oh, rdy, err, lw, ew;
    logic [2:0]   rq;
    logic         bz, tmo;
    int           g, pick;
    if (rst) begin
      g  = 0;
      bz = 1'b0;
    end else begin
      g  = mo[m];
      bz = mb[m];
    end
    oh  = bz ? (4'b0001 << g) : 4'b0000;
    tmo = bz && (mc[m] == TMO) && !t_rdy && !t_err;
    rdy = t_rdy ? oh : 4'b0000;
    err = (t_err || tmo) ? oh : 4'b0000;
    lw  = t_lw ? oh : 4'b0000;
    ew  = t_ew ? oh : 4'b0000;
    rq  = bz ? {t_wt[g], t_rd[g], t_rdl[g]} : 3'b000;
    e = {bz, 2'(g), rq, rdy, err, lw, ew, tmo, t_pa[g*32 +: 32], t_size[g*4 +: 4],
         t_wd[g*32 +: 32], t_rdata, t_ac};
    if (m == 0) eq0.push_back(e);
    else        eq1.push_back(e);
    if ((rdy | err) != 4'b0000) begin
      if (m == 0) cq0.push_back({2'(g), rdy, err, tmo});
      else        cq1.push_back({2'(g), rdy, err, tmo});
    end

    if (rst) begin
      mb[m] = 1'b0; mo[m] = 0; mc[m] = 0; ml[m] = NCH - 1;
    end else if (!mb[m]) begin
      if ((t_wt | t_rd | t_rdl) != 4'b0000) begin
        pick = -1;
        if (m == 0) begin
          for (int i = NCH - 1; i >= 0; i--)
            if (pick < 0 && (t_wt[i] || t_rd[i] || t_rdl[i])) pick = i;
        end else begin
          for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (ml[m] + k) % NCH;
            if (pick < 0 && (t_wt[c] || t_rd[c] || t_rdl[c])) pick = c;
          end
        end
        mb[m] = 1'b1; mo[m] = pick; ml[m] = pick; mc[m] = 1;
      end
    end else if (t_rdy || t_err || tmo) begin
      mb[m] = 1'b0; mc[m] = 0;
    end else begin
      mc[m] = mc[m] + 1;
    end
  endtask

  task automatic drive(input int c);
    t_size  = 16'($urandom);
    t_pa    = {$urandom, $urandom, $urandom, $urandom};
    t_wd    = {$urandom, $urandom, $urandom, $urandom};
    t_rdata = $urandom;
    t_ac    = 11'($urandom);
    t_lw    = 1'($urandom);
    t_ew    = 1'($urandom);
    rst     = (c < 4) || (c >= 900 && $urandom_range(0, 99) < 3);
    if (c < 12) begin
      t_wt = 4'b0000; t_rd = 4'b0101; t_rdl = 4'b0000;
      t_rdy = (c == 8); t_err = 1'b0;
    end else if (c < 400) begin
      t_wt  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      t_rd  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      t_rdl = 4'($urandom) & 4'($urandom) & 4'($urandom);
      t_rdy = ($urandom_range(0, 3) == 0);
      t_err = ($urandom_range(0, 9) == 0);
    end else if (c < 600) begin
      t_wt = 4'b0000; t_rd = 4'b1111; t_rdl = 4'b0000;
      t_rdy = 1'b1; t_err = 1'b0;
    end else if (c < 900) begin
      t_wt  = 4'($urandom) & 4'($urandom);
      t_rd  = 4'($urandom) & 4'($urandom);
      t_rdl = 4'($urandom) & 4'($urandom);
      t_rdy = 1'b0; t_err = 1'b0;
    end else begin
      t_wt  = 4'($urandom) & 4'($urandom);
      t_rd  = 4'($urandom) & 4'($urandom);
      t_rdl = 4'($urandom) & 4'($urandom);
      t_rdy = ($urandom_range(0, 4) == 0);
      t_err = ($urandom_range(0, 9) == 0);
    end
  endtask

  // Monitor: per-cycle output check, plus completion check whenever rdy/err appear.
  task automatic mon(input int m);
    logic [133:0] a, e;
    logic [10:0]  ca, ce;
    bit           have;
    a = (m == 0) ? act[0] : act[1];
    have = (m == 0) ? (eq0.size() != 0) : (eq1.size() != 0);
    if (have) begin
      if (m == 0) e = eq0.pop_front();
      else        e = eq1.pop_front();
      n_total++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle dut%0d t=%0t: got %h want %h", m, $time, a, e);
      end
    end
    if (a[127:120] != 8'h00) begin
      ca = {a[132:131], a[127:124], a[123:120], a[111]};
      n_total++;
      have = (m == 0) ? (cq0.size() != 0) : (cq1.size() != 0);
      if (!have) begin
        n_bad++;
        $display("FAIL completion dut%0d t=%0t: got %h want none", m, $time, ca);
      end else begin
        if (m == 0) ce = cq0.pop_front();
        else        ce = cq1.pop_front();
        if (ca !== ce) begin
          n_bad++;
          $display("FAIL completion dut%0d t=%0t: got %h want %h", m, $time, ca, ce);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    rst = 1'b1;
    t_wt = '0; t_rd = '0; t_rdl = '0; t_size = '0; t_pa = '0; t_wd = '0;
    t_rdata = '0; t_ac = '0; t_lw = 1'b0; t_ew = 1'b0; t_rdy = 1'b0; t_err = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mb[m] = 1'b0; mo[m] = 0; mc[m] = 0; ml[m] = NCH - 1;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    #1;
    n_total++;
    if (eq0.size() + eq1.size() + cq0.size() + cq1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries want 0",
               eq0.size() + eq1.size() + cq0.size() + cq1.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
